// File: rtl/router_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// router_cfg_ctrl_if
//   Host / router side signal bundle of the route-table configuration
//   sequencer.
//
//   master : host side  (drives writes, commit and sync; sees status and
//            the active route buses)
//   slave  : sequencer  (router_cfg_ctrl)
//
//   wr_en/wr_ch/wr_loc/wr_sel : shadow-table write, qualified by wr_ready
//   wr_ready                  : writes are accepted (IDLE or WAIT)
//   wr_err                    : one-cycle pulse after a rejected write
//   commit / sync             : apply request / safe-switch strobe
//   busy / done / dirty       : status
//   rloc / rsel               : active route table driven to the router
// ---------------------------------------------------------------------------
interface router_cfg_ctrl_if;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [2:0]  wr_loc;
    logic [1:0]  wr_sel;
    logic        wr_ready;
    logic        wr_err;
    logic        commit;
    logic        sync;
    logic        busy;
    logic        done;
    logic        dirty;
    logic [23:0] rloc;
    logic [15:0] rsel;

    modport master (
        output wr_en, wr_ch, wr_loc, wr_sel, commit, sync,
        input  wr_ready, wr_err, busy, done, dirty, rloc, rsel
    );

    modport slave (
        input  wr_en, wr_ch, wr_loc, wr_sel, commit, sync,
        output wr_ready, wr_err, busy, done, dirty, rloc, rsel
    );
endinterface

// File: rtl/router_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// router_cfg_ctrl
//   Configuration sequencer for the 8-channel signal router. Keeps a
//   host-writable shadow route table and applies it to the active table
//   with break-before-make: changed channels are first forced to select 00
//   for BLANK_CYCLES cycles, then their location switches, then their new
//   select is applied. Commits can optionally wait for a SYNC strobe.
//
//   Ports:
//     clk_i : system clock
//     rst_i : asynchronous active-high reset
//     bus   : router_cfg_ctrl_if.slave (write port, commit/sync, status,
//             active RLoc[23:0] / RSel[15:0])
// ---------------------------------------------------------------------------
module router_cfg_ctrl #(
    parameter int BLANK_CYCLES = 4,   // legal 1..255
    parameter int WAIT_SYNC    = 1    // 1: commit waits for SYNC
) (
    input  logic             clk_i,
    input  logic             rst_i,
    router_cfg_ctrl_if.slave bus
);
    localparam logic [23:0] RESET_LOC  = 24'hFAC688;   // channel i -> location i
    localparam logic [7:0]  BLANK_LOAD = 8'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BLANK,
        ST_SWITCH,
        ST_MAKE
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] sh_loc_q, sh_loc_d, act_loc_q, act_loc_d;
    logic [15:0] sh_sel_q, sh_sel_d, act_sel_q, act_sel_d;
    logic [7:0]  mask_q, mask_d, mask_now;
    logic [7:0]  cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        done_q, done_d;
    logic        wr_err_q, wr_err_d;
    logic        dirty_q, dirty_d;

    logic        wr_ready, wr_legal, wr_accept;
    logic        eval_start, blank_load, switch_en, make_en;

    assign wr_ready  = (state_q == ST_IDLE) || (state_q == ST_WAIT);
    // Byte channels 0-3 reach locations 0..4, bit channels 4-7 reach 4..7.
    assign wr_legal  = bus.wr_ch[2] ? (bus.wr_loc >= 3'd4) : (bus.wr_loc <= 3'd4);
    assign wr_accept = bus.wr_en && wr_ready && wr_legal;
    assign wr_err_d  = bus.wr_en && wr_ready && !wr_legal;
    assign dirty_d   = (sh_loc_q != act_loc_q) || (sh_sel_q != act_sel_q);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            localparam logic [2:0] CH = 3'(gi);
            logic hit;
            assign hit = wr_accept && (bus.wr_ch == CH);

            assign sh_loc_d[3*gi +: 3] = hit ? bus.wr_loc : sh_loc_q[3*gi +: 3];
            assign sh_sel_d[2*gi +: 2] = hit ? bus.wr_sel : sh_sel_q[2*gi +: 2];

            // Compared against the post-write shadow so a write in the same
            // cycle as the commit (or SYNC) is part of that commit.
            assign mask_now[gi] = (sh_loc_d[3*gi +: 3] != act_loc_q[3*gi +: 3]) ||
                                  (sh_sel_d[2*gi +: 2] != act_sel_q[2*gi +: 2]);

            assign act_loc_d[3*gi +: 3] = (switch_en && mask_q[gi]) ?
                                          sh_loc_q[3*gi +: 3] : act_loc_q[3*gi +: 3];

            assign act_sel_d[2*gi +: 2] = (blank_load && mask_now[gi]) ? 2'b00 :
                                          (make_en && mask_q[gi])      ? sh_sel_q[2*gi +: 2] :
                                                                         act_sel_q[2*gi +: 2];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        pending_d  = pending_q;
        done_d     = 1'b0;
        eval_start = 1'b0;
        blank_load = 1'b0;
        switch_en  = 1'b0;
        make_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.commit) begin
                    if (WAIT_SYNC != 0) state_d = ST_WAIT;
                    else                eval_start = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.sync) eval_start = 1'b1;
            end
            ST_BLANK: begin
                pending_d = pending_q | bus.commit;
                if (cnt_q == 8'd0) begin
                    state_d   = ST_SWITCH;
                    switch_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SWITCH: begin
                pending_d = pending_q | bus.commit;
                state_d   = ST_MAKE;
                make_en   = 1'b1;
                done_d    = 1'b1;
            end
            ST_MAKE: begin
                // A queued commit re-evaluates the mask and never waits for SYNC.
                if (pending_q || bus.commit) begin
                    pending_d  = 1'b0;
                    eval_start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (eval_start) begin
            if (mask_now == 8'd0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d    = ST_BLANK;
                mask_d     = mask_now;
                cnt_d      = BLANK_LOAD;
                blank_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sh_loc_q  <= RESET_LOC;
            sh_sel_q  <= 16'h0000;
            act_loc_q <= RESET_LOC;
            act_sel_q <= 16'h0000;
            mask_q    <= 8'd0;
            cnt_q     <= 8'd0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            dirty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_loc_q  <= sh_loc_d;
            sh_sel_q  <= sh_sel_d;
            act_loc_q <= act_loc_d;
            act_sel_q <= act_sel_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            wr_err_q  <= wr_err_d;
            dirty_q   <= dirty_d;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.wr_err   = wr_err_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.dirty    = dirty_q;
    assign bus.rloc     = act_loc_q;
    assign bus.rsel     = act_sel_q;
endmodule
